// File: rtl/ser_xfer_ctrl_pkg.sv
// Shared definitions for the serial transfer sequencer: state encodings and default register width.
package ser_xfer_ctrl_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ser_xfer_ctrl_bit_down_counter.sv
// Loadable down counter holding the bits remaining in a transfer; saturates at zero.
module bit_down_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          zero
);

  assign zero = (count == '0);

  // Clear has priority over load so a simultaneous clear/start leaves the count at zero.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ser_xfer_ctrl.sv
// Serial transfer sequencer: drives shift_ctrl for exactly N clocks per start, with stall support.
// Optional macro SER_XFER_CIRC_EN: circ_sel follows busy so the source register recirculates.
module ser_xfer_ctrl
  import ser_xfer_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic          hold,
  output logic          shift_ctrl,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count,
  output logic          circ_sel
);

  localparam logic [CW-1:0] WIDTH_CW = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_CW   = CW'(1);

  state_t        state, next_state;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] len_clamped;

  assign len_clamped = ((len == '0) || (len > WIDTH_CW)) ? WIDTH_CW : len;

  bit_down_counter #(.CW(CW)) u_counter (
    .clk      (clk),
    .clear    (clear),
    .load     (cnt_load),
    .load_val (len_clamped),
    .en       (cnt_dec),
    .count    (count),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A zero count in SHIFT cannot occur after a clamped load; it is treated as finished rather than stuck.
  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          cnt_load   = 1'b1;
          next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_zero) begin
          next_state = S_DONE;
        end else if (!hold) begin
          cnt_dec = 1'b1;
          if (count == ONE_CW) begin
            next_state = S_DONE;
          end
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  assign busy       = (state == S_SHIFT);
  assign shift_ctrl = busy && !hold;
  assign done       = (state == S_DONE);

`ifdef SER_XFER_CIRC_EN
  assign circ_sel = busy;
`else
  assign circ_sel = 1'b0;
`endif

endmodule

// File: tb/tb_ser_xfer_ctrl.sv
// Self-checking bench for ser_xfer_ctrl: directed scenarios plus random traffic against a cycle reference model.
module tb_ser_xfer_ctrl;
  import ser_xfer_ctrl_pkg::*;

  localparam int WIDTH = DEF_WIDTH;
  localparam int CW    = $clog2(WIDTH + 1);

  logic          clk = 1'b0;
  logic          clear, start, hold;
  logic [CW-1:0] len;
  logic          shift_ctrl, busy, done, circ_sel;
  logic [CW-1:0] count;

  int check_count = 0;
  int pass_count  = 0;

  // Reference model: bits remaining, pending done pulse, and shifts seen in the current transfer.
  int m_rem    = 0;
  bit m_done   = 1'b0;
  int m_len    = 0;
  int m_shifts = 0;

  logic [WIDTH-1:0] src_reg, dst_reg;
  logic             obs_shift, obs_circ;

  always #5 clk = ~clk;

  ser_xfer_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .len        (len),
    .hold       (hold),
    .shift_ctrl (shift_ctrl),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .circ_sel   (circ_sel)
  );

  function automatic int clamp_ref(input int l);
    return ((l == 0) || (l > WIDTH)) ? WIDTH : l;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [CW-1:0] l, input logic h, input logic c);
    start = s;
    len   = l;
    hold  = h;
    clear = c;
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance model and datapath at the edge.
  task automatic run_cycle(input logic s, input int l, input logic h, input logic c);
    logic          exp_circ;
    logic [CW-1:0] lv;
    lv = l[CW-1:0];
    applyStimulus(s, lv, h, c);
    @(negedge clk);
`ifdef SER_XFER_CIRC_EN
    exp_circ = (m_rem > 0);
`else
    exp_circ = 1'b0;
`endif
    checkOutput("busy",       8'(busy),       8'(m_rem > 0));
    checkOutput("shift_ctrl", 8'(shift_ctrl), 8'((m_rem > 0) && !h));
    checkOutput("done",       8'(done),       8'(m_done));
    checkOutput("count",      8'(count),      8'(m_rem));
    checkOutput("circ_sel",   8'(circ_sel),   8'(exp_circ));
    if (m_done) begin
      checkOutput("shifts_per_xfer", 8'(m_shifts), 8'(m_len));
    end
    obs_shift = shift_ctrl;
    obs_circ  = circ_sel;
    if (obs_shift) m_shifts++;
    @(posedge clk);
    if (obs_shift) begin
      dst_reg = {src_reg[0], dst_reg[WIDTH-1:1]};
      src_reg = {(obs_circ ? src_reg[0] : 1'b0), src_reg[WIDTH-1:1]};
    end
    if (c) begin
      m_rem  = 0;
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_rem > 0) begin
      if (!h) begin
        m_rem--;
        if (m_rem == 0) m_done = 1'b1;
      end
    end else if (s) begin
      m_len    = clamp_ref(int'(lv));
      m_rem    = m_len;
      m_shifts = 0;
    end
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_datapath(input string tag, input logic [WIDTH-1:0] original);
    logic [WIDTH-1:0] exp_src;
`ifdef SER_XFER_CIRC_EN
    exp_src = original;
`else
    exp_src = '0;
`endif
    checkOutput({tag, "_dst"}, 8'(dst_reg), 8'(original));
    checkOutput({tag, "_src"}, 8'(src_reg), 8'(exp_src));
  endtask

  initial begin
    src_reg = '0;
    dst_reg = '0;
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    run_cycle(1'b0, 0, 1'b0, 1'b1);
    idle_cycles(1);

    // Full default-length transfer moves the source into the destination.
    src_reg = 4'b0110;
    dst_reg = '0;
    run_cycle(1'b1, 0, 1'b0, 1'b0);
    idle_cycles(6);
    check_datapath("t1", 4'b0110);

    run_cycle(1'b1, 2, 1'b0, 1'b0);
    idle_cycles(4);

    run_cycle(1'b1, 4, 1'b0, 1'b0);
    idle_cycles(2);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 0, 1'b1, 1'b0);
    idle_cycles(4);

    run_cycle(1'b1, 4, 1'b0, 1'b0);
    idle_cycles(2);
    run_cycle(1'b0, 0, 1'b0, 1'b1);
    idle_cycles(2);
    run_cycle(1'b1, 3, 1'b0, 1'b0);
    idle_cycles(5);

    for (int i = 0; i < 14; i++) run_cycle(1'b1, 2, 1'b0, 1'b0);
    idle_cycles(2);

    run_cycle(1'b1, 7, 1'b0, 1'b0);
    idle_cycles(6);

    run_cycle(1'b1, 1, 1'b0, 1'b1);
    idle_cycles(2);

    src_reg = 4'b1011;
    dst_reg = '0;
    run_cycle(1'b1, 0, 1'b0, 1'b0);
    idle_cycles(6);
    check_datapath("t6", 4'b1011);

    for (int i = 0; i < 400; i++) begin
      run_cycle(($urandom_range(2) == 0), int'($urandom_range(2**CW - 1)),
                ($urandom_range(3) == 0), ($urandom_range(39) == 0));
    end
    idle_cycles(8);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
